// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, round keys
// fetched from an external key store addressed by rk_idx_o.
module aes_decrypt_iter (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [127:0] ciphertext_i,
   output logic [3:0]   rk_idx_o,
   input  logic [127:0] round_key_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [127:0] plaintext_o,
   output logic         busy_o
);

   typedef enum logic [1:0] {IDLE, ROUND, LAST, DONE} state_e;

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   state_e       state_q, state_d;
   logic [127:0] data_q, data_d;
   logic [3:0]   rc_q, rc_d;
   logic [127:0] invSr, invSb, addKey, invMc;
   logic         accept;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Byte (r,c) of the state lives at index r + 4c, byte 0 in the top bits.
   function automatic logic [127:0] invShiftRows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] invSubBytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
      end
      return o;
   endfunction

   // Multiples by 9, b, d, e are built from the x2/x4/x8 doubling chain.
   function automatic logic [31:0] invMixColumn(input logic [31:0] col);
      logic [7:0] a [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   function automatic logic [127:0] invMixColumns(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         o[127-32*c -: 32] = invMixColumn(s[127-32*c -: 32]);
      end
      return o;
   endfunction

   assign invSr  = invShiftRows(data_q);
   assign invSb  = invSubBytes(invSr);
   assign addKey = invSb ^ round_key_i;
   assign invMc  = invMixColumns(addKey);
   assign accept = in_valid_i && (state_q == IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ROUND;
         ROUND:   if (rc_q == 4'd1) state_d = LAST;
         LAST:    state_d = DONE;
         DONE:    if (out_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready_o  = 1'b0;
      busy_o      = 1'b1;
      out_valid_o = 1'b0;
      rk_idx_o    = 4'd10;
      case (state_q)
         IDLE: begin
            in_ready_o = 1'b1;
            busy_o     = 1'b0;
         end
         ROUND:   rk_idx_o    = rc_q;
         LAST:    rk_idx_o    = 4'd0;
         DONE:    out_valid_o = 1'b1;
         default: busy_o      = 1'b0;
      endcase
   end

   // The state register doubles as the plaintext holding register in DONE/IDLE.
   always_comb begin
      data_d = data_q;
      rc_d   = rc_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               data_d = ciphertext_i ^ round_key_i;
               rc_d   = 4'd9;
            end
         end
         ROUND: begin
            data_d = invMc;
            rc_d   = (rc_q == 4'd1) ? 4'd0 : rc_q - 4'd1;
         end
         LAST:    data_d = addKey;
         DONE:    if (out_ready_i) rc_d = 4'd10;
         default: rc_d = 4'd10;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= '0;
         rc_q   <= 4'd10;
      end else begin
         data_q <= data_d;
         rc_q   <= rc_d;
      end
   end

   assign plaintext_o = data_q;

endmodule
